// File: rtl/des_pipe_scheduler.sv
// des_pipe_scheduler
// Round-robin scheduler sharing a single pipelined DES core between NREQ
// requesters. At most one block is issued per cycle; each block's requester
// ID travels down a tag pipe matched to the core latency so the result can be
// returned to its originator. sched_en stops granting and lets the pipe drain
// (for key or configuration changes).
//
// Optional feature macro: DES_SCHED_TAGCHK_EN
//   defined   -> adds sticky output tag_err. It sets whenever core_output_valid
//                disagrees with the tag-tail valid bit. A core result that
//                arrives without a matching tag is not forwarded.
//   undefined -> no tag_err port. Responses are driven from the tag pipe only
//                and core_output_valid is ignored.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   sched_en            1 = grant requests, 0 = stop granting and drain
//   req_valid/req_ready per-requester handshake; req_ready is a one-hot grant
//   req_msg, req_keys   per-requester plaintext (64b) and round keys (768b)
//   rsp_valid, rsp_data one-hot result strobe and shared ciphertext
//   idle, in_flight     scheduler idle and count of outstanding blocks
//   core_*              connection to the shared DES core
module des_pipe_scheduler #(
  parameter int NREQ     = 4,
  parameter int PIPE_LAT = 17,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sched_en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*64-1:0]    req_msg,
  input  logic [NREQ*768-1:0]   req_keys,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [63:0]           rsp_data,
  output logic                  idle,
  output logic [IDW+5:0]        in_flight,
  output logic                  core_start,
  output logic [63:0]           core_message,
  output logic [767:0]          core_round_keys,
  input  logic                  core_output_valid,
  input  logic [63:0]           core_result
`ifdef DES_SCHED_TAGCHK_EN
  ,
  output logic                  tag_err
`endif
);

  // The tag pipe is loaded from the registered core_start, one edge after the
  // handshake, so it needs one extra slot for its tail to line up with the
  // core's output valid.
  localparam int TAG_DEPTH = PIPE_LAT + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            hs;

  logic [IDW-1:0]  issue_id_p0;
  logic [TAG_DEPTH-1:0] tag_v_p1;
  logic [IDW-1:0]  tag_id_p1 [TAG_DEPTH];
  logic            tail_v;
  logic [IDW-1:0]  tail_id;
  logic            deliver;

  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
    logic [IDW:0] n;
    n = {1'b0, id} + (IDW+1)'(1);
    if (n == (IDW+1)'(NREQ)) n = '0;
    return n[IDW-1:0];
  endfunction

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    logic         found;
    logic [IDW:0] pos;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    pos    = '0;
    if (state == S_RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        pos = {1'b0, ptr} + (IDW+1)'(k);
        if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
        if (!found && req_valid[pos[IDW-1:0]]) begin
          found            = 1'b1;
          gnt[pos[IDW-1:0]] = 1'b1;
          gnt_id           = pos[IDW-1:0];
        end
      end
    end
  end

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (sched_en) state <= S_RUN;
        S_RUN:   if (!sched_en) state <= S_DRAIN;
        S_DRAIN: begin
          if (sched_en)              state <= S_RUN;
          else if (in_flight == '0)  state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (hs) ptr <= next_ptr(gnt_id);
    end
  end

  // ---- p0: issue register towards the core ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_start      <= 1'b0;
      core_message    <= '0;
      core_round_keys <= '0;
      issue_id_p0     <= '0;
    end else begin
      core_start <= hs;
      if (hs) begin
        core_message    <= req_msg[gnt_id*64 +: 64];
        core_round_keys <= req_keys[gnt_id*768 +: 768];
        issue_id_p0     <= gnt_id;
      end
    end
  end

  // ---- p1: tag pipe tracking the core latency ----
  always_ff @(posedge clk) begin
    if (!rst_n) tag_v_p1 <= '0;
    else        tag_v_p1 <= {tag_v_p1[TAG_DEPTH-2:0], core_start};
  end

  always_ff @(posedge clk) begin
    tag_id_p1[0] <= issue_id_p0;
    for (int i = 1; i < TAG_DEPTH; i++) tag_id_p1[i] <= tag_id_p1[i-1];
  end

  assign tail_v  = tag_v_p1[TAG_DEPTH-1];
  assign tail_id = tag_id_p1[TAG_DEPTH-1];

`ifdef DES_SCHED_TAGCHK_EN
  assign deliver = tail_v & core_output_valid;

  always_ff @(posedge clk) begin
    if (!rst_n)                          tag_err <= 1'b0;
    else if (core_output_valid != tail_v) tag_err <= 1'b1;
  end
`else
  logic unused_core_valid;
  assign unused_core_valid = core_output_valid;
  assign deliver           = tail_v;
`endif

  // ---- p2: registered response ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= deliver ? (NREQ'(1) << tail_id) : '0;
      if (deliver) rsp_data <= core_result;
    end
  end

  // A tag retiring from the tail always leaves the count, even if the core
  // result was rejected, so the count cannot stick above zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      case ({core_start, tail_v})
        2'b10:   in_flight <= in_flight + (IDW+6)'(1);
        2'b01:   in_flight <= in_flight - (IDW+6)'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign idle = (state == S_IDLE) && (in_flight == '0);

endmodule

// File: tb/tb_des_pipe_scheduler.sv
// Testbench for des_pipe_scheduler: behavioural pipelined core model, grant
// tracker that pushes expected responses, and a response monitor that pops
// and compares them.
module tb_des_pipe_scheduler;

  localparam int NREQ     = 4;
  localparam int PIPE_LAT = 17;
  localparam int IDW      = 2;
  localparam logic [63:0] DES_PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] DES_CT = 64'h85E813540F0AB405;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                sched_en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*64-1:0]  req_msg;
  logic [NREQ*768-1:0] req_keys;
  logic [NREQ-1:0]     rsp_valid;
  logic [63:0]         rsp_data;
  logic                idle;
  logic [IDW+5:0]      in_flight;
  logic                core_start;
  logic [63:0]         core_message;
  logic [767:0]        core_round_keys;
  logic                core_output_valid;
  logic [63:0]         core_result;
  logic                force_cov;
`ifdef DES_SCHED_TAGCHK_EN
  logic                tag_err;
`endif

  des_pipe_scheduler #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_msg(req_msg), .req_keys(req_keys),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .idle(idle), .in_flight(in_flight),
    .core_start(core_start), .core_message(core_message),
    .core_round_keys(core_round_keys),
    .core_output_valid(core_output_valid), .core_result(core_result)
`ifdef DES_SCHED_TAGCHK_EN
    , .tag_err(tag_err)
`endif
  );

  always #5 clk = ~clk;

  // Round keys K1..K16 of DES key 133457799BBCDFF1, K1 in bits [47:0].
  function automatic logic [767:0] k_std();
    logic [47:0]  k [16];
    logic [767:0] r;
    k[0]  = 48'b000110_110000_001011_101111_111111_000111_000001_110010;
    k[1]  = 48'b011110_011010_111011_011001_110110_111100_100111_100101;
    k[2]  = 48'b010101_011111_110010_001010_010000_101100_111110_011001;
    k[3]  = 48'b011100_101010_110111_010110_110110_110011_010100_011101;
    k[4]  = 48'b011111_001110_110000_000111_111010_110101_001110_101000;
    k[5]  = 48'b011000_111010_010100_111110_010100_000111_101100_101111;
    k[6]  = 48'b111011_001000_010010_110111_111101_100001_100010_111100;
    k[7]  = 48'b111101_111000_101000_111010_110000_010011_101111_111011;
    k[8]  = 48'b111000_001101_101111_101011_111011_011110_011110_000001;
    k[9]  = 48'b101100_011111_001101_000111_101110_100100_011001_001111;
    k[10] = 48'b001000_010101_111111_010011_110111_101101_001110_000110;
    k[11] = 48'b011101_010111_000111_110101_100101_000110_011111_101001;
    k[12] = 48'b100101_111100_010111_010001_111110_101011_101001_000001;
    k[13] = 48'b010111_110100_001110_110111_111100_101110_011100_111010;
    k[14] = 48'b101111_111001_000110_001101_001111_010011_111100_001010;
    k[15] = 48'b110010_110011_110110_001011_000011_100001_011111_110101;
    r = '0;
    for (int i = 0; i < 16; i++) r[48*i +: 48] = k[i];
    return r;
  endfunction

  // Stand-in for the DES core: the standard vector maps to its known
  // ciphertext, anything else to a cheap keyed mix.
  function automatic logic [63:0] core_fn(input logic [63:0] m, input logic [767:0] k);
    if (m == DES_PT && k == k_std()) return DES_CT;
    return m ^ k[63:0] ^ k[767:704] ^ 64'hC3C3_0F0F_5A5A_9696;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] r;
    r = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  // Core model: valid appears PIPE_LAT edges after the edge sampling start.
  logic [PIPE_LAT:0] cm_v;
  logic [63:0]       cm_r [PIPE_LAT+1];
  always @(posedge clk) begin
    if (!rst_n) cm_v <= '0;
    else        cm_v <= {cm_v[PIPE_LAT-1:0], core_start};
    cm_r[0] <= core_fn(core_message, core_round_keys);
    for (int i = 1; i <= PIPE_LAT; i++) cm_r[i] <= cm_r[i-1];
  end
  assign core_output_valid = cm_v[PIPE_LAT] | force_cov;
  assign core_result       = cm_r[PIPE_LAT];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Grant tracker: a grant seen mid-cycle becomes a handshake at the next edge.
  exp_t trk_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          trk_e.id   = i;
          trk_e.data = core_fn(req_msg[64*i +: 64], req_keys[768*i +: 768]);
          trk_e.cyc  = cyc + PIPE_LAT + 3;
          exp_q.push_back(trk_e);
          grant_log.push_back(i);
        end
      end
    end
  end

  // Response monitor.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=%b rsp_data=%h, nothing outstanding (cycle %0d)",
                 rsp_valid, rsp_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_owner", 64'(rsp_valid), 64'(onehot(mon_e.id)));
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    tick(n);
    exp_q.delete();
    grant_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [63:0] msg, input logic [63:0] seed);
    req_msg[64*i +: 64]    = msg;
    req_keys[768*i +: 768] = {12{seed}};
  endtask

  task automatic wait_drained(input int bound, input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick(1);
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic issue_one(input int id, input int bound);
    bit got;
    got = 1'b0;
    req_valid[id] = 1'b1;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid[id] = 1'b0;
    check("grant_seen", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int seen;
    int k;
    rst_n     = 1'b0;
    sched_en  = 1'b1;
    req_valid = '1;
    req_msg   = '0;
    req_keys  = '0;
    force_cov = 1'b0;

    // Reset with every requester asking.
    tick(2);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_core_start", 64'(core_start), 64'd0);
    check("reset_idle", 64'(idle), 64'd1);
    check("reset_in_flight", 64'(in_flight), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
`ifdef DES_SCHED_TAGCHK_EN
    check("reset_tag_err", 64'(tag_err), 64'd0);
`endif

    // Single block with the standard DES vector.
    req_valid = '0;
    req_msg[63:0]   = DES_PT;
    req_keys[767:0] = k_std();
    tick(1);
    rst_n = 1'b1;
    tick(2);
    issue_one(0, 10);
    check("issue_core_start", 64'(core_start), 64'd1);
    check("issue_core_message", core_message, DES_PT);
    check("issue_core_keys", 64'(core_round_keys == k_std()), 64'd1);
    wait_drained(40, "single_all_returned");

    // Fairness: all four requesters for 12 cycles.
    for (int i = 0; i < NREQ; i++) set_req(i, 64'h1111_0000_0000_0000 * (i + 1) + 64'(i), 64'hA000_0000_0000_0001 + 64'(i));
    do_reset(1);
    tick(2);
    req_valid = '1;
    tick(12);
    req_valid = '0;
    @(negedge clk);
    check("fair_grant_count", 64'(grant_log.size()), 64'd12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++)
      check("fair_grant_order", 64'(grant_log[i]), 64'(i % NREQ));
    wait_drained(60, "fair_all_returned");

    // A single active requester is granted every cycle.
    grant_log.delete();
    req_valid = 4'b0100;
    tick(4);
    req_valid = '0;
    @(negedge clk);
    check("single_req_rate", 64'(grant_log.size()), 64'd4);
    wait_drained(60, "single_req_returned");
    tick(1);
    check("in_flight_zero", 64'(in_flight), 64'd0);

    // Drain: five issues, then sched_en low with requests still pending.
    do_reset(1);
    tick(2);
    req_valid = '1;
    tick(4);
    sched_en = 1'b0;
    tick(1);
    bad = 0;
    k   = 0;
    @(negedge clk);
    while (in_flight != 0 && k < 60) begin
      if (req_ready != '0) bad++;
      @(negedge clk);
      k++;
    end
    check("drain_no_ready", 64'(bad), 64'd0);
    check("drain_in_flight_zero", 64'(in_flight), 64'd0);
    check("drain_idle_same_cycle", 64'(idle), 64'd0);
    @(negedge clk);
    check("drain_idle_next_cycle", 64'(idle), 64'd1);
    check("drain_ready_after", 64'(req_ready), 64'd0);
    check("drain_grant_count", 64'(grant_log.size()), 64'd5);
    check("drain_all_returned", 64'(exp_q.size()), 64'd0);
    req_valid = '0;
    sched_en  = 1'b1;

    // Reset while six blocks are in flight.
    tick(1);
    do_reset(1);
    tick(2);
    req_valid = '1;
    tick(6);
    req_valid = '0;
    tick(1);
    @(negedge clk);
    check("midflight_count", 64'(in_flight), 64'd6);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    tick(1);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    check("midflight_no_rsp", 64'(seen), 64'd0);
    check("midflight_in_flight", 64'(in_flight), 64'd0);

`ifdef DES_SCHED_TAGCHK_EN
    // Core valid with an empty tag tail.
    sched_en = 1'b0;
    tick(3);
    force_cov = 1'b1;
    tick(1);
    force_cov = 1'b0;
    @(negedge clk);
    check("tag_err_set", 64'(tag_err), 64'd1);
    tick(5);
    @(negedge clk);
    check("tag_err_sticky", 64'(tag_err), 64'd1);
    check("tag_err_no_rsp", 64'(rsp_valid), 64'd0);
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
